// File: rtl/jump_unit_if.sv
// Bus between the control/fetch side and the branch-resolution unit.
// JUMP_LINK_EN adds the registered return address (linkAddress).
interface jump_unit_if #(
  parameter int AW = 11,
  parameter int CW = 3
);
  logic          jumpSignal;
  logic [CW-1:0] IR;
  logic [AW-1:0] PC;
  logic [AW-1:0] Address;
  logic          ZF;
  logic          CF;
  logic [AW-1:0] jumpAddress;
  logic          taken;
`ifdef JUMP_LINK_EN
  logic [AW-1:0] linkAddress;
`endif

  // Control/fetch side: drives the instruction fields and flags, reads the next PC.
  modport master (
    output jumpSignal, IR, PC, Address, ZF, CF,
`ifdef JUMP_LINK_EN
    input  linkAddress,
`endif
    input  jumpAddress, taken
  );

  // Branch-resolution side.
  modport slave (
    input  jumpSignal, IR, PC, Address, ZF, CF,
`ifdef JUMP_LINK_EN
    output linkAddress,
`endif
    output jumpAddress, taken
  );
endinterface

// File: rtl/jump_unit.sv
// Branch-resolution unit: decodes the jump condition against ZF/CF and
// registers the next-PC selection (target when taken, sequential PC otherwise).
// Optional feature macro: JUMP_LINK_EN (registered return address for calls).
module jump_unit #(
  parameter int AW = 11,
  parameter int CW = 3
) (
  input logic        clk,
  input logic        rst,
  jump_unit_if.slave bus
);

  logic          w_cond;
  logic          w_take;
  logic [AW-1:0] r_jumpAddress;
  logic          r_taken;

  // Condition decode; unknown/reserved codes fall to the default and never take.
  always_comb begin
    w_cond = 1'b0;
    case (bus.IR)
      3'b000:  w_cond = 1'b1;
      3'b001:  w_cond = bus.ZF;
      3'b010:  w_cond = bus.CF;
      3'b011:  w_cond = ~bus.ZF;
      3'b100:  w_cond = ~bus.CF;
      3'b101:  w_cond = bus.ZF | bus.CF;
      3'b110:  w_cond = ~bus.ZF & ~bus.CF;
      default: w_cond = 1'b0;
    endcase
  end

  // Ternary gate keeps an unknown IR from leaking through when no jump is issued.
  assign w_take = bus.jumpSignal ? w_cond : 1'b0;

  // Next-PC selection and taken flag, one cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jumpAddress <= '0;
      r_taken       <= 1'b0;
    end else begin
      r_jumpAddress <= w_take ? bus.Address : bus.PC;
      r_taken       <= w_take;
    end
  end

  assign bus.jumpAddress = r_jumpAddress;
  assign bus.taken       = r_taken;

`ifdef JUMP_LINK_EN
  logic [AW-1:0] r_linkAddress;

  // Capture the return address only on a taken jump; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_linkAddress <= '0;
    else if (w_take) r_linkAddress <= bus.PC;
  end

  assign bus.linkAddress = r_linkAddress;
`endif

endmodule

// File: tb/tb_jump_unit.sv
// Directed test of jump_unit with hand-computed expected values.
module tb_jump_unit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  jump_unit_if #(.AW(11), .CW(3)) bus ();

  jump_unit #(.AW(11), .CW(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one vector, clock it in, check both registered outputs.
  task automatic vec(input string tag, input logic js, input logic [2:0] ir,
                     input logic [10:0] pc, input logic [10:0] addr,
                     input logic zf, input logic cf,
                     input logic [10:0] exp_a, input logic exp_t);
    bus.jumpSignal = js;
    bus.IR         = ir;
    bus.PC         = pc;
    bus.Address    = addr;
    bus.ZF         = zf;
    bus.CF         = cf;
    @(posedge clk);
    #1;
    chk({tag, ".addr"}, {21'd0, bus.jumpAddress}, {21'd0, exp_a});
    chk({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, exp_t});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.jumpSignal = 1'b0;
    bus.IR = 3'b000;
    bus.PC = 11'd0;
    bus.Address = 11'd0;
    bus.ZF = 1'b0;
    bus.CF = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.addr", {21'd0, bus.jumpAddress}, 32'd0);
    chk("rst.taken", {31'd0, bus.taken}, 32'd0);
`ifdef JUMP_LINK_EN
    chk("rst.link", {21'd0, bus.linkAddress}, 32'd0);
`endif
    rst = 1'b0;

    vec("nojmp",   1'b0, 3'b000, 11'd0,  11'd1,    1'b0, 1'b1, 11'd0,    1'b0);
    vec("jz0",     1'b1, 3'b001, 11'd3,  11'd1,    1'b0, 1'b0, 11'd3,    1'b0);
    vec("jz1",     1'b1, 3'b001, 11'd3,  11'd1,    1'b1, 1'b0, 11'd1,    1'b1);
    vec("jc0",     1'b1, 3'b010, 11'd16, 11'd1025, 1'b0, 1'b0, 11'd16,   1'b0);
    vec("jc1",     1'b1, 3'b010, 11'd16, 11'd1025, 1'b0, 1'b1, 11'd1025, 1'b1);
    vec("jnz0",    1'b1, 3'b011, 11'd16, 11'd1025, 1'b0, 1'b1, 11'd1025, 1'b1);
    vec("jnz1",    1'b1, 3'b011, 11'd16, 11'd1025, 1'b1, 1'b0, 11'd16,   1'b0);
    vec("jnc0",    1'b1, 3'b100, 11'd1,  11'd6,    1'b0, 1'b0, 11'd6,    1'b1);
    vec("jnc1",    1'b1, 3'b100, 11'd1,  11'd6,    1'b0, 1'b1, 11'd1,    1'b0);
    vec("jbe00",   1'b1, 3'b101, 11'd16, 11'd1025, 1'b0, 1'b0, 11'd16,   1'b0);
    vec("jbe01",   1'b1, 3'b101, 11'd16, 11'd1025, 1'b0, 1'b1, 11'd1025, 1'b1);
    vec("jbe11",   1'b1, 3'b101, 11'd16, 11'd1025, 1'b1, 1'b1, 11'd1025, 1'b1);
    vec("jbe10",   1'b1, 3'b101, 11'd16, 11'd1025, 1'b1, 1'b0, 11'd1025, 1'b1);
    vec("ja00",    1'b1, 3'b110, 11'd16, 11'd1025, 1'b0, 1'b0, 11'd1025, 1'b1);
    vec("ja01",    1'b1, 3'b110, 11'd16, 11'd1025, 1'b0, 1'b1, 11'd16,   1'b0);
    vec("ja10",    1'b1, 3'b110, 11'd16, 11'd1025, 1'b1, 1'b0, 11'd16,   1'b0);
    vec("ja11",    1'b1, 3'b110, 11'd16, 11'd1025, 1'b1, 1'b1, 11'd16,   1'b0);
    vec("rsv00",   1'b1, 3'b111, 11'd40, 11'd900,  1'b0, 1'b0, 11'd40,   1'b0);
    vec("rsv11",   1'b1, 3'b111, 11'd41, 11'd900,  1'b1, 1'b1, 11'd41,   1'b0);
    vec("pcmax",   1'b1, 3'b001, 11'd2047, 11'd5,  1'b0, 1'b0, 11'd2047, 1'b0);
    vec("admax",   1'b1, 3'b000, 11'd7,  11'd2047, 1'b0, 1'b0, 11'd2047, 1'b1);
    vec("js0jbe",  1'b0, 3'b101, 11'd77, 11'd555,  1'b1, 1'b1, 11'd77,   1'b0);
    vec("js0jmp",  1'b0, 3'b000, 11'd78, 11'd555,  1'b1, 1'b1, 11'd78,   1'b0);

    // Flag flips between edges: only the value present at the edge counts.
    bus.jumpSignal = 1'b1; bus.IR = 3'b001; bus.PC = 11'd200; bus.Address = 11'd300;
    bus.ZF = 1'b1; bus.CF = 1'b0;
    #2 bus.ZF = 1'b0;
    @(posedge clk);
    #1;
    chk("flagflip.addr", {21'd0, bus.jumpAddress}, 32'd200);
    chk("flagflip.taken", {31'd0, bus.taken}, 32'd0);

    // Link capture, hold on not-taken, then recapture.
    vec("call",    1'b1, 3'b000, 11'd5,  11'd100,  1'b0, 1'b0, 11'd100,  1'b1);
`ifdef JUMP_LINK_EN
    chk("link.cap", {21'd0, bus.linkAddress}, 32'd5);
`endif
    vec("seq",     1'b1, 3'b001, 11'd9,  11'd100,  1'b0, 1'b0, 11'd9,    1'b0);
`ifdef JUMP_LINK_EN
    chk("link.hold", {21'd0, bus.linkAddress}, 32'd5);
`endif
    vec("call2",   1'b1, 3'b010, 11'd7,  11'd300,  1'b0, 1'b1, 11'd300,  1'b1);
`ifdef JUMP_LINK_EN
    chk("link.cap2", {21'd0, bus.linkAddress}, 32'd7);
`endif

    // Asynchronous reset pulse between edges while taken=1.
    #2 rst = 1'b1;
    #1;
    chk("arst.addr", {21'd0, bus.jumpAddress}, 32'd0);
    chk("arst.taken", {31'd0, bus.taken}, 32'd0);
`ifdef JUMP_LINK_EN
    chk("arst.link", {21'd0, bus.linkAddress}, 32'd0);
`endif
    #1 rst = 1'b0;
    vec("post",    1'b1, 3'b000, 11'd12, 11'd34,   1'b0, 1'b0, 11'd34,   1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
